// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_WIDTH-bit full-duplex transfer in any CPOL/CPHA mode,
// internal SCLK divider, MSB/LSB-first order and one-hot active-low chip selects.
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_WIDTH  = 2,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [SEL_WIDTH-1:0]  slave_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  miso,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  output logic [NUM_SLAVES-1:0] cs_n
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t                  state, state_nx;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        half_cnt;
  logic [DATA_WIDTH-1:0]   tx_sh, rx_sh, tx_sh_nx;
  logic [NUM_SLAVES-1:0]   cs_dec;
  logic                    cpol_q, cpha_q, lsb_q;
  logic                    div_end, half_last, edge_ev, lead_ev, trail_ev;
  logic                    sample_ev, shift_ev, tx_bit;

  assign div_end   = (div_cnt == DIV_LAST);
  assign half_last = (half_cnt == HALF_LAST);
  assign tx_bit    = lsb_q ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
  assign tx_sh_nx  = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);

  always_comb begin
    cs_dec = '1;
    for (int unsigned i = 0; i < NUM_SLAVES; i++)
      if (slave_sel == SEL_WIDTH'(i)) cs_dec[i] = 1'b0;
  end

  always_comb begin
    state_nx = state;
    edge_ev  = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = SETUP;
      SETUP: if (div_end) state_nx = XFER;
      XFER: begin
        edge_ev = div_end;
        if (div_end && half_last) state_nx = HOLD;
      end
      HOLD:  if (div_end) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // half_cnt even -> this toggle is a leading edge, odd -> trailing edge
    lead_ev   = edge_ev & ~half_cnt[0];
    trail_ev  = edge_ev & half_cnt[0];
    sample_ev = cpha_q ? trail_ev : lead_ev;
    shift_ev  = cpha_q ? lead_ev : (trail_ev & ~half_last);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      done <= 1'b0;

      if (state == IDLE || state == DONE || div_end) div_cnt <= '0;
      else                                           div_cnt <= div_cnt + DIV_W'(1);

      if (state != XFER) half_cnt <= '0;
      else if (edge_ev)  half_cnt <= half_cnt + BIT_W'(1);

      if (state == IDLE)                 sclk <= cpol;
      else if (edge_ev)                  sclk <= ~sclk;
      else if (state == HOLD && div_end) sclk <= cpol_q;

      case (state)
        IDLE: if (start) begin
          cpol_q <= cpol;
          cpha_q <= cpha;
          lsb_q  <= lsb_first;
          cs_n   <= cs_dec;
          busy   <= 1'b1;
          rx_sh  <= '0;
          // cpha=0 presents the first bit before the first edge; cpha=1 waits for it
          if (!cpha) begin
            mosi  <= lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];
            tx_sh <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
          end else begin
            tx_sh <= tx_data;
          end
        end
        XFER: begin
          if (shift_ev) begin
            mosi  <= tx_bit;
            tx_sh <= tx_sh_nx;
          end
          if (sample_ev)
            rx_sh <= lsb_q ? {miso, rx_sh[DATA_WIDTH-1:1]} : {rx_sh[DATA_WIDTH-2:0], miso};
        end
        HOLD: if (div_end) begin
          done    <= 1'b1;
          busy    <= 1'b0;
          cs_n    <= '1;
          mosi    <= 1'b0;
          rx_data <= rx_sh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: cycle-level transaction model for the default instance,
// directed checks for a 16-bit / CLK_DIV=1 instance.
module tb_spi_master_param;

  localparam int W    = 8;
  localparam int NS   = 3;
  localparam int CD   = 2;
  localparam int NCYC = CD * (2 * W + 2) + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         start, cpol, cpha, lsb_first, miso, busy, done, sclk, mosi;
  logic [W-1:0] tx_data, rx_data;
  logic [1:0]   slave_sel;
  logic [NS-1:0] cs_n;

  logic         s_start, s_cpol, s_cpha, s_lsb, s_miso, s_busy, s_done, s_sclk, s_mosi;
  logic [15:0]  s_tx, s_rx;
  logic [1:0]   s_sel;
  logic [2:0]   s_cs_n;

  spi_master_param #(.DATA_WIDTH(W), .NUM_SLAVES(NS), .SEL_WIDTH(2), .CLK_DIV(CD)) u_dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .slave_sel(slave_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .miso(miso), .rx_data(rx_data),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .cs_n(cs_n));

  spi_master_param #(.DATA_WIDTH(16), .NUM_SLAVES(3), .SEL_WIDTH(2), .CLK_DIV(1)) u_dut16 (
    .clk(clk), .reset(reset), .start(s_start), .tx_data(s_tx), .slave_sel(s_sel),
    .cpol(s_cpol), .cpha(s_cpha), .lsb_first(s_lsb), .miso(s_miso), .rx_data(s_rx),
    .busy(s_busy), .done(s_done), .sclk(s_sclk), .mosi(s_mosi), .cs_n(s_cs_n));

  assign s_miso = s_mosi;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // slave: shifts slv_word out MSB first, advancing on the mode's shift edges
  bit       loop_en = 1'b1;
  logic [W-1:0] slv_word = 8'h8F;
  int       slv_edges = 0;
  logic     slv_bit;
  always @(sclk) slv_edges++;
  always_comb begin
    int idx;
    idx = cpha ? ((slv_edges == 0) ? 0 : (slv_edges - 1) / 2) : slv_edges / 2;
    if (idx > W - 1) idx = W - 1;
    slv_bit = slv_word[W-1-idx];
  end
  assign miso = loop_en ? mosi : slv_bit;

  int rise1 = 0, rise16 = 0;
  always @(posedge sclk)   rise1++;
  always @(posedge s_sclk) rise16++;

  // transaction model: which cycle of the transfer we are in decides every output
  int        edge_n = 0, t0 = 0;
  bit        active = 1'b0, chk_en = 1'b0;
  logic      m_cpol, m_cpha, m_lsb, idle_sclk = 1'b0;
  logic [1:0] m_sel;
  logic [W-1:0] m_tx, m_rx, held_rx = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active = 1'b0; held_rx = '0; idle_sclk = 1'b0;
    end else begin
      edge_n++;
      if (active && (edge_n - t0 == NCYC + 1)) begin
        active = 1'b0; held_rx = m_rx;
      end else if (!active && start) begin
        active = 1'b1; t0 = edge_n - 1;
        m_cpol = cpol; m_cpha = cpha; m_lsb = lsb_first; m_sel = slave_sel; m_tx = tx_data;
        m_rx = loop_en ? tx_data : slv_word;
      end
      idle_sclk = cpol;
    end
  end

  always @(negedge clk) begin : cmp
    int k, tog, nb;
    logic [NS-1:0] ecs;
    logic emosi;
    if (reset && chk_en) begin
      if (!active) begin
        check("idle busy", busy, 0);
        check("idle done", done, 0);
        check("idle cs_n", cs_n, 3'b111);
        check("idle mosi", mosi, 0);
        check("idle sclk", sclk, idle_sclk);
        check("idle rx_data", rx_data, held_rx);
      end else begin
        k = edge_n - t0;
        tog = (k - 1) / CD - 1;
        if (tog < 0) tog = 0;
        if (tog > 2 * W) tog = 2 * W;
        check("xfer sclk", sclk, m_cpol ^ tog[0]);
        if (k < NCYC) begin
          ecs = '1;
          if (m_sel < NS) ecs[m_sel] = 1'b0;
          if (m_cpha) nb = ((tog + 1) / 2 > W) ? W : (tog + 1) / 2;
          else        nb = 1 + ((tog / 2 > W - 1) ? W - 1 : tog / 2);
          emosi = (nb == 0) ? 1'b0 : m_tx[m_lsb ? nb - 1 : W - nb];
          check("xfer busy", busy, 1);
          check("xfer done", done, 0);
          check("xfer cs_n", cs_n, ecs);
          check("xfer mosi", mosi, emosi);
          check("xfer rx_data", rx_data, held_rx);
        end else begin
          check("done busy", busy, 0);
          check("done pulse", done, 1);
          check("done cs_n", cs_n, 3'b111);
          check("done rx_data", rx_data, m_rx);
        end
      end
    end
  end

  task automatic do_xfer(input logic [W-1:0] tx, input logic [1:0] sel, input logic pol,
                         input logic pha, input logic lsb, input bit loop, input bit pulse10,
                         output int done_k, output int dones, output logic [NS-1:0] cs_mid);
    @(posedge clk); #1;
    cpol = pol; cpha = pha; lsb_first = lsb; loop_en = loop; slave_sel = sel; tx_data = tx;
    repeat (3) @(posedge clk);
    #1;
    slv_edges = 0; rise1 = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tx_data = ~tx; slave_sel = sel + 2'd1; lsb_first = ~lsb;
    done_k = -1; dones = 0; cs_mid = 'x;
    for (int i = 1; i <= NCYC + 10; i++) begin
      @(negedge clk);
      if (i == 10) begin cs_mid = cs_n; if (pulse10) start = 1'b1; end
      if (i == 11) start = 1'b0;
      if (done) begin dones++; if (done_k < 0) done_k = i; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dk, nd, first_bit;
    logic [NS-1:0] csm;
    start = 0; tx_data = '0; slave_sel = '0; cpol = 0; cpha = 0; lsb_first = 0;
    s_start = 0; s_tx = '0; s_sel = '0; s_cpol = 0; s_cpha = 0; s_lsb = 0;

    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sclk", sclk, 0);
    check("reset mosi", mosi, 0);
    check("reset cs_n", cs_n, 3'b111);
    check("reset rx_data", rx_data, 0);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;

    do_xfer(8'hA5, 2'd0, 0, 0, 0, 1, 0, dk, nd, csm);
    check("mode0 done cycle", dk, 37);
    check("mode0 done count", nd, 1);
    check("mode0 rx_data", rx_data, 8'hA5);
    check("mode0 sclk rises", rise1, 8);
    check("mode0 cs_n mid", csm, 3'b110);

    for (int m = 0; m < 4; m++) begin
      do_xfer(8'h3C, 2'd1, logic'(m / 2), logic'(m % 2), 0, 0, 0, dk, nd, csm);
      check("slave done cycle", dk, 37);
      check("slave rx_data", rx_data, 8'h8F);
      check("slave cs_n mid", csm, 3'b101);
      check("slave sclk after", sclk, logic'(m / 2));
    end

    do_xfer(8'h3C, 2'd2, 0, 1, 1, 1, 0, dk, nd, csm);
    check("lsb rx_data", rx_data, 8'h3C);
    check("lsb cs_n mid", csm, 3'b011);

    do_xfer(8'hC3, 2'd3, 0, 0, 0, 1, 1, dk, nd, csm);
    check("badsel cs_n mid", csm, 3'b111);
    check("badsel done cycle", dk, 37);
    check("badsel done count", nd, 1);
    check("badsel rx_data", rx_data, 8'hC3);

    // reset asserted mid-transfer discards it
    @(posedge clk); #1;
    cpol = 0; cpha = 0; lsb_first = 0; loop_en = 1; slave_sel = 2'd1; tx_data = 8'h69;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nd = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    #1 reset = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset cs_n", cs_n, 3'b111);
    check("midreset sclk", sclk, 0);
    check("midreset rx_data", rx_data, 0);
    check("midreset mosi", mosi, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midreset no done", nd, 0);
    do_xfer(8'h5A, 2'd0, 0, 0, 0, 1, 0, dk, nd, csm);
    check("after reset done cycle", dk, 37);
    check("after reset rx_data", rx_data, 8'h5A);

    // 16-bit, CLK_DIV=1, LSB first, loopback
    @(posedge clk); #1;
    s_lsb = 1; s_tx = 16'h0001; s_sel = 2'd0; rise16 = 0; s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0; s_tx = 16'hFFFF;
    dk = -1; nd = 0; first_bit = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) first_bit = int'(s_mosi);
      if (i == 5) begin
        check("w16 busy mid", s_busy, 1);
        check("w16 cs_n mid", s_cs_n, 3'b110);
      end
      if (s_done) begin nd++; if (dk < 0) dk = i; end
    end
    check("w16 first mosi", first_bit, 1);
    check("w16 done cycle", dk, 35);
    check("w16 done count", nd, 1);
    check("w16 rx_data", s_rx, 16'h0001);
    check("w16 sclk rises", rise16, 16);
    check("w16 sclk idle", s_sclk, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master: next generation of the team's fixed 8-bit, three-slave SPI master. Serialises a `DATA_WIDTH`-bit word on `mosi` and deserialises `miso` into `rx_data` in all four CPOL/CPHA modes. Adds an internal SCLK divider, selectable MSB/LSB-first order, a `start`/`busy`/`done` handshake and a one-hot active-low chip select for `NUM_SLAVES` slaves. Sits between the host register/control logic and the off-chip SPI pins; all logic runs on the single system clock.

## Interface
- `DATA_WIDTH`, 8: bits per transfer, ≥2.
- `NUM_SLAVES`, 3: number of chip-select lines, ≥1.
- `SEL_WIDTH`, 2: width of `slave_sel`; 2^SEL_WIDTH ≥ NUM_SLAVES.
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles, ≥1.
- `clk` in 1: system clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: transfer request, sampled in IDLE only.
- `tx_data` in DATA_WIDTH: word to send, latched on accepted `start`.
- `slave_sel` in SEL_WIDTH: target slave index, latched on accepted `start`.
- `cpol` in 1: SCLK idle level, latched on accepted `start`.
- `cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge, latched on accepted `start`.
- `lsb_first` in 1: 1 = LSB shifted first, latched on accepted `start`.
- `miso` in 1: serial data from slave.
- `rx_data` out DATA_WIDTH: last received word, held until next `done`.
- `busy` out 1: high while a transfer is in progress.
- `done` out 1: one-cycle pulse at transfer end.
- `sclk` out 1: serial clock.
- `mosi` out 1: serial data to slave.
- `cs_n` out NUM_SLAVES: active-low one-hot chip selects.

## Operation
- States: IDLE → SETUP → XFER → HOLD → DONE → IDLE.
- IDLE: `sclk` follows live `cpol` input; `cs_n` all ones; `mosi` 0. `start`=1 latches config and `tx_data` into shift register, moves to SETUP.
- SETUP (CLK_DIV cycles): selected `cs_n[slave_sel]` low; `sclk` = latched cpol; if cpha=0, first data bit driven on `mosi` on SETUP entry.
- XFER: 2·DATA_WIDTH SCLK half-periods, each CLK_DIV cycles; `sclk` toggles at the end of every half-period. Odd toggles are leading edges, even toggles trailing.
  - cpha=0: sample `miso` at leading edge, shift next bit onto `mosi` at trailing edge (no shift after last trailing edge).
  - cpha=1: shift bit onto `mosi` at leading edge (first bit at first leading edge), sample at trailing edge.
  - Sampling: `miso` registered in the `clk` cycle in which `sclk` toggles to the sample edge.
  - Bit order: lsb_first=0 sends `tx_data[DATA_WIDTH-1]` first and fills rx from MSB down; lsb_first=1 sends bit 0 first and fills rx from bit 0 up.
- HOLD (CLK_DIV cycles): `sclk` at idle level, `cs_n` still asserted.
- DONE (1 cycle): `cs_n` all ones, `done`=1, `busy`=0, `rx_data` updated with the assembled word; next cycle IDLE.
- `slave_sel` ≥ NUM_SLAVES: transfer runs with full timing, no `cs_n` asserted, `rx_data` still updated.
- `start` outside IDLE (including the DONE cycle) ignored; input changes during transfer ignored.
- Bit counter width: clog2(2·DATA_WIDTH)+1; divider counter width: clog2(CLK_DIV)+1.

## Timing
- Reset (async assert, any state): state IDLE, `busy`=0, `done`=0, `sclk`=0, `mosi`=0, `cs_n` all ones, `rx_data`=0, shift/counters cleared; partial transfer discarded, no `done`. Release synchronous to `clk`.
- Cycle 0 = `start` sampled in IDLE. `busy` and `cs_n` assert at cycle 1.
- `done` at cycle CLK_DIV·(2·DATA_WIDTH+2)+1; defaults (8, 2) → cycle 37, `busy` high cycles 1–36.
- SCLK frequency = f_clk / (2·CLK_DIV), 50 % duty.
- Earliest next `start` accepted at cycle after `done`.

## Test plan
- Mode 0 (cpol=0, cpha=0), defaults, slave_sel=0, tx=0xA5, miso looped to mosi → `rx_data`=0xA5, `cs_n`=3'b110 during busy, `done` at cycle 37, exactly 8 rising sclk edges.
- All four modes with slave model returning 0x8F MSB-first → `rx_data`=0x8F each mode; `sclk` idle level equals cpol before and after; mosi changes only on shift edges.
- lsb_first=1, tx=0x01, loopback, DATA_WIDTH=16, CLK_DIV=1 → first mosi bit 1, `rx_data`=0x0001, `done` at cycle 35.
- slave_sel=3 with NUM_SLAVES=3 → `cs_n` stays 3'b111 throughout, `done` still at cycle 37; `start` pulsed at cycle 10 → ignored, single `done`.
- Reset low at cycle 15 mid-transfer → immediately `busy`=0, `cs_n`=3'b111, `sclk`=0, `rx_data`=0, no `done`; new transfer after release completes normally.
